// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy block.
//   - bus geometry: BUS_AW (byte address width), BUS_DW (data width), WORD_BYTES
//   - LEN_W: width of the word-count input (0..256 words)
//   - dma_state_e: copy-engine state encoding
//   - next_addr(): advance a byte address by one word, wrapping modulo 2^BUS_AW
package dma_pkg;

    localparam int unsigned BUS_AW     = 16;
    localparam int unsigned BUS_DW     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_W      = 9;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } dma_state_e;

    // Natural overflow of the BUS_AW-bit sum gives the required wrap; low bits are kept.
    function automatic logic [BUS_AW-1:0] next_addr(input logic [BUS_AW-1:0] addr);
        return addr + BUS_AW'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/dma_copy_if.sv
// Memory-bus interface between the dma_copy initiator and a responder.
//   rd_en, rd_addr        : single-cycle read request and byte address (initiator)
//   rd_data, rd_valid     : read response, data qualified by rd_valid (responder)
//   wr_en, wr_addr, wr_data : posted single-cycle write (initiator)
// Modports: master (dma_copy side), slave (memory/responder side).
interface dma_copy_if import dma_pkg::*; ();

    logic              rd_en;
    logic [BUS_AW-1:0] rd_addr;
    logic [BUS_DW-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [BUS_AW-1:0] wr_addr;
    logic [BUS_DW-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/dma_timeout.sv
// Read-response watchdog for dma_copy.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : arm the counter with CYCLES
//   count      : one more cycle spent waiting
//   expire     : high in the CYCLES-th consecutive counted cycle after load
module dma_timeout #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CYCLES);
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Fires while the last remaining cycle is being counted.
    assign expire = count && !load && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_copy.sv
// Word-at-a-time memory copy engine (bus initiator).
//   clk, rst_n          : clock, synchronous active-low reset
//   start, abort        : begin a copy (accepted only when idle) / cancel it
//   src_addr, dst_addr  : byte addresses of first source/destination word
//   len                 : number of 32-bit words (0..256)
//   busy, done, error   : copy in progress / end-of-copy pulse / sticky read timeout
//   bus                 : dma_copy_if master port (read request/response, posted write)
// Build option: DMA_COPY_TIMEOUT_EN enables the read timeout (TIMEOUT_CYCLES) and
// the error flag; without it a read waits forever and error is tied low.
module dma_copy import dma_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BUS_AW-1:0] src_addr,
    input  logic [BUS_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    dma_copy_if.master        bus
);

    dma_state_e        state_q, state_d;
    logic [BUS_AW-1:0] src_q, src_d;
    logic [BUS_AW-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [BUS_DW-1:0] data_q, data_d;

`ifdef DMA_COPY_TIMEOUT_EN
    logic error_q, error_d;
    logic tmo_expire;

    dma_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == StRead),
        .count  ((state_q == StWait) && !bus.rd_valid),
        .expire (tmo_expire)
    );
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef DMA_COPY_TIMEOUT_EN
        error_d = error_q;
`endif
        if (abort) begin
            // Abort wins over start and rd_valid; nothing is captured.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = len;
`ifdef DMA_COPY_TIMEOUT_EN
                        error_d = 1'b0;
`endif
                        state_d = (len == '0) ? StDone : StRead;
                    end
                end
                StRead: begin
                    state_d = StWait;
                end
                StWait: begin
                    if (bus.rd_valid) begin
                        data_d  = bus.rd_data;
                        state_d = StWrite;
                    end
`ifdef DMA_COPY_TIMEOUT_EN
                    else if (tmo_expire) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
                StWrite: begin
                    src_d   = next_addr(src_q);
                    dst_d   = next_addr(dst_q);
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? StDone : StRead;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef DMA_COPY_TIMEOUT_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef DMA_COPY_TIMEOUT_EN
            error_q <= error_d;
`endif
        end
    end

    // Outputs decode directly from state so a reset edge clears them immediately.
    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        bus.rd_en   = (state_q == StRead);
        bus.wr_en   = (state_q == StWrite);
        bus.rd_addr = bus.rd_en ? src_q  : '0;
        bus.wr_addr = bus.wr_en ? dst_q  : '0;
        bus.wr_data = bus.wr_en ? data_q : '0;
`ifdef DMA_COPY_TIMEOUT_EN
        error       = error_q;
`else
        error       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: RAM-like responder with variable latency,
// bus monitor, and a word-list reference model of the expected copy traffic.
module tb_dma_copy;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [8:0]  len = '0;
    logic        busy, done, error;

    dma_copy_if bus ();

    dma_copy #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int overlap_err = 0;
    int zero_err = 0;
    logic [15:0] rd_log[$];
    logic [15:0] wa_log[$];
    logic [31:0] wd_log[$];

    int          rsp_cnt = 0;
    int          rsp_lat = 1;
    bit          spur = 1'b0;
    logic [15:0] rsp_addr = '0;
    logic [31:0] seed = '0;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {a ^ 16'h5a3c, ~a} ^ seed;
    endfunction

    function automatic bit mapped(input logic [15:0] a);
        return (a < 16'h2000) || (a >= 16'hf000);
    endfunction

    // Monitor and responder, both acting mid-cycle.
    always @(negedge clk) begin
        if (bus.rd_en) rd_log.push_back(bus.rd_addr);
        else if (bus.rd_addr !== 16'h0) zero_err++;
        if (bus.wr_en) begin
            wa_log.push_back(bus.wr_addr);
            wd_log.push_back(bus.wr_data);
        end else if (bus.wr_addr !== 16'h0 || bus.wr_data !== 32'h0) begin
            zero_err++;
        end
        if (bus.rd_en && bus.wr_en) overlap_err++;
        if (done === 1'b1) n_done++;

        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = word_at(rsp_addr);
            end
        end else if (spur && (bus.rd_en || bus.wr_en)) begin
            // Junk response outside WAIT must be ignored.
            bus.rd_valid = 1'b1;
            bus.rd_data  = $urandom;
        end
        if (bus.rd_en && mapped(bus.rd_addr)) begin
            rsp_addr = bus.rd_addr;
            rsp_cnt  = rsp_lat;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        n_done = 0;
    endtask

    task automatic check_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                              input int l);
        int bad = 0;
        for (int i = 0; i < l; i++) begin
            logic [15:0] ea;
            logic [15:0] ed;
            ea = s + 16'(4 * i);
            ed = d + 16'(4 * i);
            if (i >= rd_log.size() || rd_log[i] !== ea) bad++;
            if (i >= wa_log.size() || wa_log[i] !== ed || wd_log[i] !== word_at(ea)) bad++;
        end
        chk({tag, ".nrd"}, 64'(rd_log.size()), 64'(l));
        chk({tag, ".nwr"}, 64'(wa_log.size()), 64'(l));
        chk({tag, ".words"}, 64'(bad), 64'd0);
    endtask

    // Returns the number of cycles from busy rising to the done pulse, or -1.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [8:0] l,
                            input int lat, input bit sp, output int k);
        rsp_lat = lat;
        spur    = sp;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        len      = 9'($urandom);
        k = -1;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          nrd;
        logic [15:0] s, d;
        logic [8:0]  l;
        int          lat;
        bit          sp;

        seed = $urandom;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        chk("rst.en", {bus.rd_en, bus.wr_en}, 0);
        chk("rst.bus", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-word copy, 1-cycle responder
        clear_logs();
        run_copy(16'h0000, 16'h0100, 9'd4, 1, 1'b0, k);
        chk("s1.cycles", 64'(k), 64'd12);
        check_copy("s1", 16'h0000, 16'h0100, 4);
        chk("s1.error", error, 0);
        chk("s1.ndone", 64'(n_done), 64'd1);

        // Zero length: immediate done, no traffic
        clear_logs();
        run_copy(16'h0040, 16'h0080, 9'd0, 1, 1'b0, k);
        chk("len0.cycles", 64'(k), 64'd0);
        chk("len0.nrd", 64'(rd_log.size()), 64'd0);
        chk("len0.nwr", 64'(wa_log.size()), 64'd0);
        chk("len0.ndone", 64'(n_done), 64'd1);

        // Address wrap
        clear_logs();
        run_copy(16'hfffc, 16'hfff8, 9'd2, 1, 1'b0, k);
        chk("wrap.cycles", 64'(k), 64'd6);
        check_copy("wrap", 16'hfffc, 16'hfff8, 2);
        if (rd_log.size() > 1) chk("wrap.rd1", rd_log[1], 16'h0000);

        // Random copies: unaligned addresses, variable latency, junk rd_valid
        for (int it = 0; it < 6; it++) begin
            s   = 16'($urandom_range(0, 16'h0fff));
            d   = 16'($urandom);
            l   = 9'($urandom_range(1, 12));
            lat = $urandom_range(1, 4);
            sp  = 1'($urandom_range(0, 1));
            clear_logs();
            run_copy(s, d, l, lat, sp, k);
            chk("rnd.cycles", 64'(k), 64'(l * (lat + 2)));
            check_copy("rnd", s, d, int'(l));
            chk("rnd.ndone", 64'(n_done), 64'd1);
        end
        spur = 1'b0;

        // Abort during WAIT of word 2
        clear_logs();
        rsp_lat = 3;
        @(negedge clk);
        src_addr = 16'h0300;
        dst_addr = 16'h0600;
        len      = 9'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (rd_log.size() == 2 && !bus.rd_en) begin
                k = i;
                break;
            end
        end
        chk("abort.reach_wait", 64'(k >= 0), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        chk("abort.idle", busy, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("abort.nrd", 64'(rd_log.size()), 64'd2);
        chk("abort.nwr", 64'(wa_log.size()), 64'd1);
        chk("abort.ndone", 64'(n_done), 64'd0);

`ifdef DMA_COPY_TIMEOUT_EN
        // Read timeout on an unmapped source
        clear_logs();
        rsp_lat = 1;
        @(negedge clk);
        src_addr = 16'h2000;
        dst_addr = 16'h0700;
        len      = 9'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("tmo.cycles", 64'(k), 64'd8);
        chk("tmo.error", error, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("tmo.sticky", error, 1);
        chk("tmo.nwr", 64'(wa_log.size()), 64'd0);
        chk("tmo.ndone", 64'(n_done), 64'd1);
        clear_logs();
        @(negedge clk);
        src_addr = 16'h0010;
        dst_addr = 16'h0020;
        len      = 9'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("tmo.clear", error, 0);
        repeat (6) @(negedge clk);
        #1;
        check_copy("tmo.next", 16'h0010, 16'h0020, 1);
`else
        // No timeout: WAIT holds indefinitely, error stays low
        clear_logs();
        rsp_lat = 1;
        @(negedge clk);
        src_addr = 16'h2000;
        dst_addr = 16'h0700;
        len      = 9'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("notmo.busy", busy, 1);
        chk("notmo.error", error, 0);
        chk("notmo.ndone", 64'(n_done), 64'd0);
        chk("notmo.nwr", 64'(wa_log.size()), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("notmo.abort", busy, 0);
`endif

        // Start while busy is ignored
        clear_logs();
        rsp_lat = 1;
        @(negedge clk);
        src_addr = 16'h0400;
        dst_addr = 16'h0800;
        len      = 9'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        src_addr = 16'h0900;
        dst_addr = 16'h0a00;
        len      = 9'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_copy("busystart", 16'h0400, 16'h0800, 3);
        chk("busystart.ndone", 64'(n_done), 64'd1);
        chk("busystart.idle", busy, 0);

        // Reset mid-copy, with start held during the reset edge
        clear_logs();
        @(negedge clk);
        src_addr = 16'h0500;
        dst_addr = 16'h0b00;
        len      = 9'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        len   = 9'd2;
        @(negedge clk);
        #1;
        nrd = rd_log.size();
        chk("midrst.busy", busy, 0);
        chk("midrst.flags", {done, error}, 0);
        chk("midrst.en", {bus.rd_en, bus.wr_en}, 0);
        chk("midrst.bus", {bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("midrst.nrd", 64'(rd_log.size()), 64'(nrd));
        chk("midrst.ndone", 64'(n_done), 64'd0);

        chk("bus.overlap", 64'(overlap_err), 64'd0);
        chk("bus.zero", 64'(zero_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
